pc_redirect_ctrl: RTL and testbench
===================================

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, range 0..7: squash cycles issued after each redirect.
REQ-002 Parameter XLEN, default 32: PC/target width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 trap_req  input  1  exception/trap redirect request.
REQ-006 trap_target  input  XLEN  trap vector address.
REQ-007 br_req  input  1  execute-stage branch/jump redirect request.
REQ-008 br_target  input  XLEN  branch target address.
REQ-009 stall_req  input  1  hazard-unit PC freeze.
REQ-010 fetch_ready  input  1  fetch stage able to accept a redirect this cycle.
REQ-011 redirect_flag  output  1  redirect strobe to fetch.
REQ-012 redirect_target  output  XLEN  new PC, valid while redirect_flag=1.
REQ-013 pc_src  output  1  1 = fetch PC mux selects redirect_target, 0 = PC+4.
REQ-014 pc_write  output  1  fetch PC register enable.
REQ-015 flush  output  1  squash IF/ID and ID/EX pipeline registers.
REQ-016 busy  output  1  state != IDLE.

Function
REQ-017 FSM states: IDLE, PEND, ISSUE, FLUSH; state, target register and flush counter are registers; outputs decoded from them.
REQ-018 Priority: trap_req over br_req; trap_target wins on simultaneous requests.
REQ-019 IDLE, request and fetch_ready=1 in cycle N: capture target; ISSUE in cycle N+1 (latency 1).
REQ-020 IDLE, request and fetch_ready=0: capture target; go PEND.
REQ-021 PEND: stay until fetch_ready=1 sampled, then ISSUE next cycle; trap_req in PEND overwrites captured target; br_req in PEND ignored.
REQ-022 ISSUE (exactly 1 cycle): redirect_flag=1, pc_src=1, pc_write=1, flush=1, redirect_target=captured target; stall_req ignored.
REQ-023 ISSUE -> FLUSH with counter loaded to FLUSH_CYCLES; FLUSH_CYCLES=0 -> IDLE directly.
REQ-024 FLUSH: flush=1, pc_write=1, pc_src=0, redirect_flag=0; counter decrements each cycle; exits to IDLE when counter reaches 1 (exactly FLUSH_CYCLES cycles).
REQ-025 trap_req in ISSUE or FLUSH: capture trap_target, restart at ISSUE (or PEND if fetch_ready=0); br_req in ISSUE/FLUSH ignored (younger, squashed).
REQ-026 IDLE outputs: redirect_flag=0, pc_src=0, flush=0, pc_write=!stall_req.
REQ-027 PEND outputs: pc_write=0, pc_src=0, redirect_flag=0, flush=1.
REQ-028 redirect_target drives captured register in all states; value meaningful only during ISSUE.
REQ-029 Request and stall_req same cycle in IDLE: request accepted; stall suppresses pc_write in that cycle only.

Reset
REQ-030 rstn=0 asynchronously forces state=IDLE, target=0, counter=0; pending request discarded.
REQ-031 While rstn=0: redirect_flag=0, pc_src=0, pc_write=0, flush=0, busy=0, redirect_target=0.
REQ-032 Reset deasserted mid-FLUSH/PEND: resume in IDLE, no redirect re-issued.

Structure
REQ-033 Shared package pc_ctrl_pkg holds state enum type and XLEN default localparam.
REQ-034 Single module, no sub-modules; flush counter width 3 bits.

Verification
REQ-035 br_req=1, br_target=0x0000_0100, fetch_ready=1 at cycle 5 -> cycle 6 redirect_flag=1, pc_src=1, target=0x100; flush=1 cycles 6-8; IDLE cycle 9.
REQ-036 trap_req+br_req same cycle, targets 0x8000_0000/0x200 -> single ISSUE with 0x8000_0000.
REQ-037 br_req with fetch_ready=0 for 3 cycles, trap_req (0x80) in second -> PEND 3 cycles, pc_write=0, then ISSUE target 0x80.
REQ-038 stall_req=1 for 2 cycles in IDLE -> pc_write=0 those cycles, pc_src=0, busy=0.
REQ-039 trap_req during FLUSH cycle 2 -> ISSUE next cycle, counter reloaded to 2; br_req in FLUSH -> no effect.
REQ-040 rstn pulsed low during FLUSH -> all outputs 0 immediately, IDLE after release, no redirect_flag.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared types and defaults for the PC redirect controller.
package pc_ctrl_pkg;

  // Default PC / target width
  localparam int unsigned XlenDefault = 32;

  // Redirect sequencing states
  typedef enum logic [1:0] {
    StIdle,
    StPend,
    StIssue,
    StFlush
  } pc_state_e;

endpackage

// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: arbitrates trap and branch redirects, hands the new PC to
// fetch once it is ready, then squashes the front-end pipeline registers for a
// fixed number of cycles.
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned XLEN         = XlenDefault
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_target,
  input  logic            br_req,
  input  logic [XLEN-1:0] br_target,
  input  logic            stall_req,
  input  logic            fetch_ready,
  output logic            redirect_flag,
  output logic [XLEN-1:0] redirect_target,
  output logic            pc_src,
  output logic            pc_write,
  output logic            flush,
  output logic            busy
);

  localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [2:0]      cnt_q, cnt_d;

  // Next-state: trap beats branch; only a trap may interrupt an in-flight redirect,
  // since any branch seen after acceptance belongs to a squashed younger instruction.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (trap_req || br_req) begin
          target_d = trap_req ? trap_target : br_target;
          state_d  = fetch_ready ? StIssue : StPend;
        end
      end
      StPend: begin
        if (trap_req) target_d = trap_target;
        if (fetch_ready) state_d = StIssue;
      end
      StIssue, StFlush: begin
        if (trap_req) begin
          target_d = trap_target;
          state_d  = fetch_ready ? StIssue : StPend;
          cnt_d    = '0;
        end else if (state_q == StIssue) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StFlush;
            cnt_d   = FlushInit;
          end
        end else if (cnt_q <= 3'd1) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State, captured target and flush counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output decode; pc_write is gated by rstn so the PC stays frozen during reset.
  always_comb begin
    redirect_flag = 1'b0;
    pc_src        = 1'b0;
    pc_write      = 1'b0;
    flush         = 1'b0;
    unique case (state_q)
      StIdle:  pc_write = rstn & ~stall_req;
      StPend:  flush = 1'b1;
      StIssue: begin
        redirect_flag = 1'b1;
        pc_src        = 1'b1;
        pc_write      = 1'b1;
        flush         = 1'b1;
      end
      StFlush: begin
        pc_write = 1'b1;
        flush    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy            = (state_q != StIdle);
  assign redirect_target = target_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed self-checking bench for pc_redirect_ctrl (FLUSH_CYCLES=2, XLEN=32).
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_pc_redirect_ctrl;

  logic        clk;
  logic        rstn;
  logic        trap_req;
  logic [31:0] trap_target;
  logic        br_req;
  logic [31:0] br_target;
  logic        stall_req;
  logic        fetch_ready;
  logic        redirect_flag;
  logic [31:0] redirect_target;
  logic        pc_src;
  logic        pc_write;
  logic        flush;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // {redirect_flag, pc_src, pc_write, flush, busy}
  logic [4:0] outs;
  assign outs = {redirect_flag, pc_src, pc_write, flush, busy};

  pc_redirect_ctrl #(
    .FLUSH_CYCLES(2),
    .XLEN        (32)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .trap_req       (trap_req),
    .trap_target    (trap_target),
    .br_req         (br_req),
    .br_target      (br_target),
    .stall_req      (stall_req),
    .fetch_ready    (fetch_ready),
    .redirect_flag  (redirect_flag),
    .redirect_target(redirect_target),
    .pc_src         (pc_src),
    .pc_write       (pc_write),
    .flush          (flush),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic t, input logic [31:0] tt, input logic b,
                        input logic [31:0] bt, input logic s, input logic fr);
    trap_req    = t;
    trap_target = tt;
    br_req      = b;
    br_target   = bt;
    stall_req   = s;
    fetch_ready = fr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (outs !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_outs got %b want %b", outs, 5'b00000);
    end
    n_checks++;
    if (redirect_target !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_target got %h want %h", redirect_target, 32'h0);
    end
    // A request seen while held in reset must be discarded
    set_in(1'b1, 32'hdead_beef, 1'b0, 32'h0, 1'b0, 1'b1);
    next_cycle();
    n_checks++;
    if (outs !== 5'b00000 || redirect_target !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hold got %b/%h want %b/%h", outs, redirect_target, 5'b00000, 32'h0);
    end
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs !== 5'b00100) begin
      n_fail++;
      $display("FAIL reset_release got %b want %b", outs, 5'b00100);
    end
    next_cycle();
  endtask

  task automatic test_branch();
    logic [4:0] exp_o [5] = '{5'b00100, 5'b11111, 5'b00111, 5'b00111, 5'b00100};
    for (int i = 0; i < 5; i++) begin
      if (i == 0) set_in(1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b0, 1'b1);
      else        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      n_checks++;
      if (outs !== exp_o[i]) begin
        n_fail++;
        $display("FAIL branch cyc%0d outs got %b want %b", i, outs, exp_o[i]);
      end
      if (i == 1) begin
        n_checks++;
        if (redirect_target !== 32'h0000_0100) begin
          n_fail++;
          $display("FAIL branch target got %h want %h", redirect_target, 32'h0000_0100);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_priority();
    logic [4:0] exp_o [5] = '{5'b00100, 5'b11111, 5'b00111, 5'b00111, 5'b00100};
    for (int i = 0; i < 5; i++) begin
      if (i == 0) set_in(1'b1, 32'h8000_0000, 1'b1, 32'h0000_0200, 1'b0, 1'b1);
      else        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      n_checks++;
      if (outs !== exp_o[i]) begin
        n_fail++;
        $display("FAIL priority cyc%0d outs got %b want %b", i, outs, exp_o[i]);
      end
      if (i == 1) begin
        n_checks++;
        if (redirect_target !== 32'h8000_0000) begin
          n_fail++;
          $display("FAIL priority target got %h want %h", redirect_target, 32'h8000_0000);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_pend();
    logic [4:0] exp_o [8] = '{5'b00100, 5'b00011, 5'b00011, 5'b00011,
                              5'b11111, 5'b00111, 5'b00111, 5'b00100};
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:       set_in(1'b0, 32'h0, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
        1:       set_in(1'b1, 32'h0000_0080, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
        2:       set_in(1'b0, 32'h0, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
        default: set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      endcase
      @(negedge clk);
      n_checks++;
      if (outs !== exp_o[i]) begin
        n_fail++;
        $display("FAIL pend cyc%0d outs got %b want %b", i, outs, exp_o[i]);
      end
      if (i == 4) begin
        n_checks++;
        if (redirect_target !== 32'h0000_0080) begin
          n_fail++;
          $display("FAIL pend target got %h want %h", redirect_target, 32'h0000_0080);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    // Two idle stall cycles, then a branch accepted under stall; stall ignored in ISSUE
    logic [4:0] exp_o [8] = '{5'b00000, 5'b00000, 5'b00100, 5'b00000,
                              5'b11111, 5'b00111, 5'b00111, 5'b00100};
    for (int i = 0; i < 8; i++) begin
      case (i)
        0, 1:    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        3:       set_in(1'b0, 32'h0, 1'b1, 32'h0000_0abc, 1'b1, 1'b1);
        4:       set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        default: set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      endcase
      @(negedge clk);
      n_checks++;
      if (outs !== exp_o[i]) begin
        n_fail++;
        $display("FAIL stall cyc%0d outs got %b want %b", i, outs, exp_o[i]);
      end
      if (i == 4) begin
        n_checks++;
        if (redirect_target !== 32'h0000_0abc) begin
          n_fail++;
          $display("FAIL stall target got %h want %h", redirect_target, 32'h0000_0abc);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_trap_in_flush();
    logic [4:0] exp_o [8] = '{5'b00100, 5'b11111, 5'b00111, 5'b00111,
                              5'b11111, 5'b00111, 5'b00111, 5'b00100};
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:       set_in(1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b0, 1'b1);
        2:       set_in(1'b0, 32'h0, 1'b1, 32'h0000_0400, 1'b0, 1'b1);
        3:       set_in(1'b1, 32'h0000_1000, 1'b0, 32'h0, 1'b0, 1'b1);
        default: set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      endcase
      @(negedge clk);
      n_checks++;
      if (outs !== exp_o[i]) begin
        n_fail++;
        $display("FAIL trap_flush cyc%0d outs got %b want %b", i, outs, exp_o[i]);
      end
      if (i == 4) begin
        n_checks++;
        if (redirect_target !== 32'h0000_1000) begin
          n_fail++;
          $display("FAIL trap_flush target got %h want %h", redirect_target, 32'h0000_1000);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_trap_in_issue_not_ready();
    logic [4:0] exp_o [7] = '{5'b00100, 5'b11111, 5'b00011, 5'b11111,
                              5'b00111, 5'b00111, 5'b00100};
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       set_in(1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b0, 1'b1);
        1:       set_in(1'b1, 32'h0000_2000, 1'b0, 32'h0, 1'b0, 1'b0);
        default: set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      endcase
      @(negedge clk);
      n_checks++;
      if (outs !== exp_o[i]) begin
        n_fail++;
        $display("FAIL trap_issue cyc%0d outs got %b want %b", i, outs, exp_o[i]);
      end
      if (i == 3) begin
        n_checks++;
        if (redirect_target !== 32'h0000_2000) begin
          n_fail++;
          $display("FAIL trap_issue target got %h want %h", redirect_target, 32'h0000_2000);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_flush();
    logic [4:0] exp_o [3] = '{5'b00100, 5'b11111, 5'b00111};
    for (int i = 0; i < 3; i++) begin
      if (i == 0) set_in(1'b0, 32'h0, 1'b1, 32'h0000_0540, 1'b0, 1'b1);
      else        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      n_checks++;
      if (outs !== exp_o[i]) begin
        n_fail++;
        $display("FAIL rst_flush cyc%0d outs got %b want %b", i, outs, exp_o[i]);
      end
      if (i < 2) next_cycle();
    end
    // Assert reset away from any clock edge, in the middle of the FLUSH state
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (outs !== 5'b00000 || redirect_target !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_flush async got %b/%h want %b/%h", outs, redirect_target,
               5'b00000, 32'h0);
    end
    next_cycle();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (outs !== 5'b00100) begin
        n_fail++;
        $display("FAIL rst_flush post cyc%0d outs got %b want %b", i, outs, 5'b00100);
      end
      next_cycle();
    end
  endtask

  initial begin
    rstn = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_branch();
    test_priority();
    test_pend();
    test_stall();
    test_trap_in_flush();
    test_trap_in_issue_not_ready();
    test_reset_mid_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
